// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong demo.
// VGA 640x480@60 timing, playfield geometry, reset positions, colours.
package pong_pkg;

    // Horizontal timing in pixels
    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;
    localparam logic [9:0] V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    // Line on which the once-per-frame update fires (inside vblank)
    localparam logic [9:0] FRAME_LINE = 10'd481;

    // Walls: top wall is y < WALL_TOP, bottom wall is WALL_BOT <= y < V_VIS
    localparam logic [9:0] WALL_TOP = 10'd8;
    localparam logic [9:0] WALL_BOT = 10'd472;

    // Paddle columns (8 pixels wide)
    localparam logic [9:0] LPAD_X = 10'd16;
    localparam logic [9:0] RPAD_X = 10'd616;
    localparam logic [9:0] PAD_W  = 10'd8;

    // Ball is lost once it passes these limits
    localparam logic [9:0] MISS_L = 10'd4;
    localparam logic [9:0] MISS_R = 10'd636;

    // Reset positions
    localparam logic [9:0] BALL_X0 = 10'd316;
    localparam logic [9:0] BALL_Y0 = 10'd236;
    localparam logic [9:0] PAD_Y0  = 10'd208;

    // Optional centre net columns
    localparam logic [9:0] NET_X0 = 10'd318;
    localparam logic [9:0] NET_X1 = 10'd321;

    // 12-bit colour {R[3:0], G[3:0], B[3:0]}
    typedef logic [11:0] rgb_t;

    localparam rgb_t RGB_BLACK = 12'h000;
    localparam rgb_t RGB_WHITE = 12'hFFF;
    localparam rgb_t RGB_RED   = 12'hF00;
    localparam rgb_t RGB_GREEN = 12'h0F0;
    localparam rgb_t RGB_GREY  = 12'h888;

endpackage

// File: rtl/pong_top_vga_sync.sv
// VGA raster generator: 25 MHz pixel enable from 50 MHz clk,
// horizontal/vertical counters, raw sync and video_on (unregistered).
module vga_sync
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick_o,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       video_on_o
);

    logic       p_tick_q;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Raster advance: one pixel per enable, line wrap bumps the line counter
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick_q) begin
            if (h_cnt_q == H_TOT - 10'd1) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_TOT - 10'd1) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Pixel enable toggle and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            p_tick_q <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
        end else begin
            p_tick_q <= ~p_tick_q;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
        end
    end

    assign p_tick_o   = p_tick_q;
    assign h_cnt_o    = h_cnt_q;
    assign v_cnt_o    = v_cnt_q;
    assign hsync_o    = !((h_cnt_q >= H_VIS + H_FP) &&
                          (h_cnt_q <  H_VIS + H_FP + H_SYNC));
    assign vsync_o    = !((v_cnt_q >= V_VIS + V_FP) &&
                          (v_cnt_q <  V_VIS + V_FP + V_SYNC));
    assign video_on_o = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

endmodule

// File: rtl/pong_top.sv
// Self-running Pong: walls, two tracking paddles, bouncing ball on VGA.
// Define PONG_CENTER_NET_EN to draw a dashed grey centre net.
module pong_top
    import pong_pkg::*;
#(
    parameter int BALL_SIZE = 8,
    parameter int BALL_V    = 2,
    parameter int PADDLE_H  = 64,
    parameter int PADDLE_V  = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       VGA_HSYNC,
    output logic       VGA_VSYNC,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B
);

    // 11-bit working widths keep every sum/compare free of wrap-around
    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [9:0]  BV      = 10'(BALL_V);
    localparam logic [10:0] PH      = 11'(PADDLE_H);
    localparam logic [10:0] PV      = 11'(PADDLE_V);
    localparam logic [10:0] PAD_MIN = {1'b0, WALL_TOP};
    localparam logic [10:0] PAD_MAX = {1'b0, WALL_BOT} - PH;

    logic       p_tick;
    logic [9:0] h_cnt, v_cnt;
    logic       hsync, vsync, video_on;

    vga_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .p_tick_o  (p_tick),
        .h_cnt_o   (h_cnt),
        .v_cnt_o   (v_cnt),
        .hsync_o   (hsync),
        .vsync_o   (vsync),
        .video_on_o(video_on)
    );

    logic frame_tick;
    assign frame_tick = p_tick && (h_cnt == '0) && (v_cnt == FRAME_LINE);

    logic [9:0] bx_q, bx_d, by_q, by_d;
    logic       dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d;
    logic [9:0] lpad_q, lpad_d, rpad_q, rpad_d;

    function automatic logic [10:0] ext(input logic [9:0] v);
        return {1'b0, v};
    endfunction

    // Move a paddle centre toward the ball centre, with dead zone and clamp
    function automatic logic [9:0] pad_next(input logic [9:0] top,
                                            input logic [9:0] ball_y);
        logic [10:0] pc, bc, t;
        pc = ext(top) + (PH >> 1);
        bc = ext(ball_y) + (BS >> 1);
        t  = ext(top);
        if (bc >= pc + PV) begin
            t = t + PV;
        end else if (pc >= bc + PV) begin
            t = t - PV;
        end
        if (t < PAD_MIN) begin
            t = PAD_MIN;
        end else if (t > PAD_MAX) begin
            t = PAD_MAX;
        end
        return t[9:0];
    endfunction

    logic l_hit, r_hit, miss;

    // Collision terms on the pre-update positions
    always_comb begin
        l_hit = (ext(bx_q) <= ext(LPAD_X) + ext(PAD_W)) &&
                (ext(bx_q) >= ext(LPAD_X)) &&
                (ext(by_q) < ext(lpad_q) + PH) &&
                (ext(by_q) + BS > ext(lpad_q));
        r_hit = (ext(bx_q) + BS >= ext(RPAD_X)) &&
                (ext(bx_q) + BS <= ext(RPAD_X) + ext(PAD_W)) &&
                (ext(by_q) < ext(rpad_q) + PH) &&
                (ext(by_q) + BS > ext(rpad_q));
        miss  = (ext(bx_q) < ext(MISS_L)) ||
                (ext(bx_q) + BS > ext(MISS_R));
    end

    // Once-per-frame physics: move with old velocity, reflect for next frame
    always_comb begin
        bx_d     = bx_q;
        by_d     = by_q;
        dx_pos_d = dx_pos_q;
        dy_pos_d = dy_pos_q;
        lpad_d   = lpad_q;
        rpad_d   = rpad_q;
        if (frame_tick) begin
            bx_d = dx_pos_q ? bx_q + BV : bx_q - BV;
            by_d = dy_pos_q ? by_q + BV : by_q - BV;
            if (ext(by_q) <= ext(WALL_TOP)) begin
                dy_pos_d = 1'b1;
            end
            if (ext(by_q) + BS >= ext(WALL_BOT)) begin
                dy_pos_d = 1'b0;
            end
            if (l_hit) begin
                dx_pos_d = 1'b1;
            end
            if (r_hit) begin
                dx_pos_d = 1'b0;
            end
            if (miss) begin
                bx_d     = BALL_X0;
                by_d     = BALL_Y0;
                dx_pos_d = ~dx_pos_q;
                dy_pos_d = dy_pos_q;
            end
            lpad_d = pad_next(lpad_q, by_q);
            rpad_d = pad_next(rpad_q, by_q);
        end
    end

    // Object state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bx_q     <= BALL_X0;
            by_q     <= BALL_Y0;
            dx_pos_q <= 1'b1;
            dy_pos_q <= 1'b1;
            lpad_q   <= PAD_Y0;
            rpad_q   <= PAD_Y0;
        end else begin
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_pos_q <= dx_pos_d;
            dy_pos_q <= dy_pos_d;
            lpad_q   <= lpad_d;
            rpad_q   <= rpad_d;
        end
    end

    logic [10:0] x, y;
    logic        ball_on, pad_on, wall_on, net_on;
    rgb_t        rgb_d, rgb_q;
    logic        hsync_q, vsync_q;

    assign x = ext(h_cnt);
    assign y = ext(v_cnt);

    // Object coverage at the current raster position
    always_comb begin
        ball_on = (x >= ext(bx_q)) && (x < ext(bx_q) + BS) &&
                  (y >= ext(by_q)) && (y < ext(by_q) + BS);
        pad_on  = ((x >= ext(LPAD_X)) && (x < ext(LPAD_X) + ext(PAD_W)) &&
                   (y >= ext(lpad_q)) && (y < ext(lpad_q) + PH)) ||
                  ((x >= ext(RPAD_X)) && (x < ext(RPAD_X) + ext(PAD_W)) &&
                   (y >= ext(rpad_q)) && (y < ext(rpad_q) + PH));
        wall_on = (y < ext(WALL_TOP)) ||
                  ((y >= ext(WALL_BOT)) && (y < ext(V_VIS)));
`ifdef PONG_CENTER_NET_EN
        net_on  = (x >= ext(NET_X0)) && (x <= ext(NET_X1)) &&
                  (y >= ext(WALL_TOP)) && (y < ext(WALL_BOT)) &&
                  (y[4] == 1'b0);
`else
        net_on  = 1'b0;
`endif
    end

    // Pixel priority mux, black during blanking
    always_comb begin
        rgb_d = RGB_BLACK;
        if (!video_on) begin
            rgb_d = RGB_BLACK;
        end else if (ball_on) begin
            rgb_d = RGB_RED;
        end else if (pad_on) begin
            rgb_d = RGB_GREEN;
        end else if (net_on) begin
            rgb_d = RGB_GREY;
        end else if (wall_on) begin
            rgb_d = RGB_WHITE;
        end
    end

    // Output registers: same one-clk latency for sync and colour
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= RGB_BLACK;
        end else begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            rgb_q   <= rgb_d;
        end
    end

    assign VGA_HSYNC = hsync_q;
    assign VGA_VSYNC = vsync_q;
    assign VGA_R     = rgb_q[11:8];
    assign VGA_G     = rgb_q[7:4];
    assign VGA_B     = rgb_q[3:0];

endmodule

// File: tb/tb_pong_top.sv
// Directed bench for pong_top: sync timing, pixel colours, frame physics,
// paddle tracking and mid-line reset. Counters are jumped to keep runs short.
module tb_pong_top;

    logic       clk;
    logic       reset;
    logic       VGA_HSYNC, VGA_VSYNC;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    int total;
    int passed;

    pong_top dut (
        .clk      (clk),
        .reset    (reset),
        .VGA_HSYNC(VGA_HSYNC),
        .VGA_VSYNC(VGA_VSYNC),
        .VGA_R    (VGA_R),
        .VGA_G    (VGA_G),
        .VGA_B    (VGA_B)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Place the raster at (x,y), then read the registered pixel
    task automatic pix(input string tag, input int px, input int py,
                       input logic [11:0] exp);
        @(negedge clk);
        dut.u_sync.h_cnt_q = 10'(px);
        dut.u_sync.v_cnt_q = 10'(py);
        @(negedge clk);
        chk(tag, {20'd0, VGA_R, VGA_G, VGA_B}, {20'd0, exp});
    endtask

    // Jump to the end of line 480 so exactly one frame update fires
    task automatic frame();
        @(negedge clk);
        dut.u_sync.h_cnt_q = 10'd799;
        dut.u_sync.v_cnt_q = 10'd480;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n, lo, hi;
        logic [11:0] net_exp;
        total  = 0;
        passed = 0;
        reset  = 1'b1;

        repeat (5) @(negedge clk);
        chk("rst_hcnt", dut.u_sync.h_cnt_q, 0);
        chk("rst_hsync", VGA_HSYNC, 1);
        chk("rst_vsync", VGA_VSYNC, 1);
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_bx", dut.bx_q, 316);
        chk("rst_pad", dut.lpad_q, 208);
        reset = 1'b0;

        // HSYNC low width and period
        n = 0;
        while (VGA_HSYNC !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        lo = 0;
        while (VGA_HSYNC === 1'b0 && lo < 4000) begin
            @(negedge clk);
            lo++;
        end
        hi = 0;
        while (VGA_HSYNC === 1'b1 && hi < 4000) begin
            @(negedge clk);
            hi++;
        end
        chk("hsync_low", lo, 192);
        chk("hsync_period", lo + hi, 1600);

        // VSYNC low width
        @(negedge clk);
        dut.u_sync.h_cnt_q = 10'd799;
        dut.u_sync.v_cnt_q = 10'd489;
        n = 0;
        while (VGA_VSYNC !== 1'b0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        lo = 0;
        while (VGA_VSYNC === 1'b0 && lo < 10000) begin
            @(negedge clk);
            lo++;
        end
        chk("vsync_low", lo, 3200);

        // Blanking and static objects in the first frame
        pix("px_0_0", 0, 0, 12'hFFF);
        pix("px_100_4", 100, 4, 12'hFFF);
        pix("px_639_479", 639, 479, 12'hFFF);
        pix("px_640_0", 640, 0, 12'h000);
        pix("px_0_480", 0, 480, 12'h000);
        pix("px_799_524", 799, 524, 12'h000);
        pix("px_320_240", 320, 240, 12'hF00);
        pix("px_20_240", 20, 240, 12'h0F0);
        pix("px_620_240", 620, 240, 12'h0F0);
        pix("px_24_240", 24, 240, 12'h000);
        pix("px_100_240", 100, 240, 12'h000);
`ifdef PONG_CENTER_NET_EN
        net_exp = 12'h888;
`else
        net_exp = 12'h000;
`endif
        pix("px_net_319_100", 319, 100, net_exp);
        pix("px_net_319_20", 319, 20, 12'h000);

        // Ten frame updates
        repeat (10) frame();
        chk("f10_bx", dut.bx_q, 336);
        chk("f10_by", dut.by_q, 256);
        chk("f10_lpad", dut.lpad_q, 226);
        chk("f10_rpad", dut.rpad_q, 226);
        pix("f10_ball_tl", 336, 256, 12'hF00);
        pix("f10_ball_br", 343, 263, 12'hF00);
        pix("f10_right_of", 344, 263, 12'h000);
        pix("f10_below", 336, 264, 12'h000);

        // Bottom-wall bounce
        @(negedge clk);
        dut.by_q     = 10'd466;
        dut.dy_pos_q = 1'b1;
        frame();
        chk("bnc1_by", dut.by_q, 468);
        chk("bnc1_dy", dut.dy_pos_q, 0);
        chk("bnc1_bx", dut.bx_q, 338);
        frame();
        chk("bnc2_by", dut.by_q, 466);
        chk("bnc2_pad", dut.lpad_q, 230);

        // Left paddle hit
        @(negedge clk);
        dut.bx_q     = 10'd18;
        dut.by_q     = 10'd240;
        dut.dx_pos_q = 1'b0;
        dut.dy_pos_q = 1'b1;
        frame();
        chk("lhit_bx", dut.bx_q, 16);
        chk("lhit_dx", dut.dx_pos_q, 1);
        chk("lhit_by", dut.by_q, 242);
        chk("lhit_pad", dut.lpad_q, 228);

        // Miss on the left
        @(negedge clk);
        dut.bx_q     = 10'd2;
        dut.by_q     = 10'd100;
        dut.dx_pos_q = 1'b0;
        dut.dy_pos_q = 1'b0;
        frame();
        chk("miss_bx", dut.bx_q, 316);
        chk("miss_by", dut.by_q, 236);
        chk("miss_dx", dut.dx_pos_q, 1);
        chk("miss_dy", dut.dy_pos_q, 0);

        // Reset in the middle of a sync pulse
        @(negedge clk);
        dut.bx_q = 10'd100;
        dut.by_q = 10'd100;
        dut.u_sync.h_cnt_q = 10'd700;
        dut.u_sync.v_cnt_q = 10'd100;
        @(negedge clk);
        chk("pre_rst_hsync", VGA_HSYNC, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_hcnt", dut.u_sync.h_cnt_q, 0);
        chk("mid_rst_vcnt", dut.u_sync.v_cnt_q, 0);
        chk("mid_rst_hsync", VGA_HSYNC, 1);
        chk("mid_rst_vsync", VGA_VSYNC, 1);
        chk("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("mid_rst_bx", dut.bx_q, 316);
        chk("mid_rst_by", dut.by_q, 236);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
